// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    // Operation sequencing: wait for operands, shift bits, present the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder: the one arithmetic cell of the bit-serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder, LSB first, one full_adder cell plus a carry flop.
// Operands arrive on a valid/ready port, the result leaves on another.
// Optional feature macro: SERIAL_ADD_SUB_SUB_EN enables subtraction (a + ~b + 1);
// without it the sub input is ignored and the block only adds.
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               carry_q,  carry_d;
    logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               c_out_q,  c_out_d;

    logic               sub_eff;
    logic               fa_s;
    logic               fa_co;

`ifdef SERIAL_ADD_SUB_SUB_EN
    // Subtraction is selected per operation, sampled together with the operands
    assign sub_eff = sub;
`else
    // Pure adder build: the sub input has no function
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
`endif

    // The single bit-slice: current LSBs of both operands plus the running carry
    full_adder u_fa (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c_in  (carry_q),
        .s     (fa_s),
        .c_out (fa_co)
    );

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: load on accept, finish after the last bit, leave DONE on handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)            state_d = RUN;
            RUN:     if (count_q == LAST_BIT) state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: load operands in IDLE, shift one bit per RUN cycle
    always_comb begin
        count_d  = count_q;
        carry_d  = carry_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as a + ~b + 1: invert b and seed the carry with 1
                    a_sr_d  = a;
                    b_sr_d  = sub_eff ? ~b : b;
                    carry_d = sub_eff;
                    count_d = '0;
                end
            end
            RUN: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                carry_d  = fa_co;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_BIT) begin
                    // Publish the result only once complete so sum never shows partial bits
                    sum_d   = {fa_s, sum_sr_q[WIDTH-1:1]};
                    c_out_d = fa_co;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; sum/c_out hold the last result until the next one completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=8). Build with or without SERIAL_ADD_SUB_SUB_EN.
module tb_serial_add_sub;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       c_out;

    int checks   = 0;
    int failures = 0;

    serial_add_sub #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation: present operands, check latency and result, optionally stall
    // the consumer for 'hold' cycles (pulsing in_valid once), then complete the handshake.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                          input int hold, input logic [7:0] es, input logic ec,
                          input string tag);
        int n;
        @(negedge clk);
        a = ta; b = tbv; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd9);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_hold_sum"}, 32'(sum), 32'(es));
            chk({tag, "_hold_c_out"}, 32'(c_out), 32'(ec));
            if (i == 0) begin
                in_valid = 1'b1; a = 8'h11; b = 8'h22;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_post_sum_kept"}, 32'(sum), 32'(es));
        chk({tag, "_post_c_out_kept"}, 32'(c_out), 32'(ec));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        logic [8:0] model;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; sub = 1'b0;

        // 1. Reset values
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // 2. Carry out of the top bit, then all zeros
        run_op(8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, "add_00_00");

        // 3. Consumer stalls 3 cycles; in_valid pulse in DONE must be ignored
        run_op(8'h5A, 8'hA5, 1'b0, 3, 8'hFF, 1'b0, "add_stall");
        repeat (12) @(negedge clk);
        chk("stall_no_capture_out_valid", 32'(out_valid), 32'd0);
        chk("stall_no_capture_sum", 32'(sum), 32'hFF);

        // 4. Reset during RUN aborts the operation
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_c_out", 32'(c_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_result", 32'(out_valid), 32'd0);
        run_op(8'h01, 8'h02, 1'b0, 0, 8'h03, 1'b0, "add_after_abort");

`ifdef SERIAL_ADD_SUB_SUB_EN
        // 5. Subtraction: no borrow, then borrow
        run_op(8'h10, 8'h03, 1'b1, 0, 8'h0D, 1'b1, "sub_10_03");
        run_op(8'h03, 8'h10, 1'b1, 0, 8'hF3, 1'b0, "sub_03_10");
        run_op(8'h42, 8'h42, 1'b1, 0, 8'h00, 1'b1, "sub_equal");
`else
        // 6. sub input ignored in the adder-only build
        run_op(8'h10, 8'h03, 1'b1, 0, 8'h13, 1'b0, "sub_ignored");
`endif

        // Random operations against an arithmetic model
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_SUB_EN
            if (rs) model = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
            else    model = {1'b0, ra} + {1'b0, rb};
`else
            model = {1'b0, ra} + {1'b0, rb};
`endif
            run_op(ra, rb, rs, 0, model[7:0], model[8], "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
